// File: rtl/lighting_pkg.sv
// Shared types and default parameters for the motion/ambient-light lamp controller.
package lighting_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned LUM_W_DEF       = 3;
    localparam int unsigned ON_THRESH_DEF   = 3;
    localparam int unsigned OFF_THRESH_DEF  = 5;
    localparam int unsigned HOLD_CYCLES_DEF = 8;

endpackage

// File: rtl/hold_timer.sv
// Saturating down-counter that times how long the lamp stays on after motion stops.
module hold_timer #(
    parameter int unsigned W        = 3,
    parameter logic [W-1:0] LOAD_VAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lighting.sv
// Lamp controller: turns on for motion in the dark, holds after motion ends, and
// uses separate on/off luminosity thresholds so flicker near one level is ignored.
module lighting
    import lighting_pkg::*;
#(
    parameter int unsigned LUM_W       = LUM_W_DEF,
    parameter int unsigned ON_THRESH   = ON_THRESH_DEF,
    parameter int unsigned OFF_THRESH  = OFF_THRESH_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LUM_W-1:0] luminosity,
    input  logic             motionSensor,
    output logic             light
);

    localparam int unsigned LUM_MAX = (1 << LUM_W) - 1;
    localparam int unsigned TMR_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if ((OFF_THRESH <= ON_THRESH) || (HOLD_CYCLES < 1) ||
        (ON_THRESH > LUM_MAX) || (OFF_THRESH > LUM_MAX)) begin : g_bad_params
        $error("lighting: illegal threshold or hold parameters");
    end

    localparam logic [LUM_W-1:0] ON_T     = ON_THRESH[LUM_W-1:0];
    localparam logic [LUM_W-1:0] OFF_T    = OFF_THRESH[LUM_W-1:0];
    localparam logic [TMR_W-1:0] HOLD_VAL = TMR_W'(HOLD_CYCLES - 1);

    state_e state_q, state_d;
    logic   light_q, light_d;
    logic   timer_load, timer_dec, timer_zero;
    logic   dark, bright;

    assign dark   = (luminosity <= ON_T);
    assign bright = (luminosity >= OFF_T);

    hold_timer #(
        .W        (TMR_W),
        .LOAD_VAL (HOLD_VAL)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        unique case (state_q)
            OFF: begin
                if (motionSensor && dark) state_d = ON;
            end
            ON: begin
                if (bright) begin
                    state_d = OFF;
                end else if (!motionSensor) begin
                    state_d    = HOLD;
                    timer_load = 1'b1;
                end
            end
            HOLD: begin
                // Brightness wins over motion, motion wins over the timer.
                if (bright) begin
                    state_d = OFF;
                end else if (motionSensor) begin
                    state_d = ON;
                end else if (timer_zero) begin
                    state_d = OFF;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
        light_d = (state_d != OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            light_q <= 1'b0;
        end else begin
            state_q <= state_d;
            light_q <= light_d;
        end
    end

    assign light = light_q;

endmodule

// File: tb/tb_lighting.sv
// Scoreboard bench for lighting: stimulus pushes model expectations, a monitor pops and compares.
module tb_lighting;

    localparam int unsigned HOLD = 8;
    localparam int unsigned ON_T = 3;
    localparam int unsigned OFF_T = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] luminosity = 3'd0;
    logic       motionSensor = 1'b0;
    logic       light;

    int checks = 0;
    int errors = 0;

    bit    exp_q[$];
    string tag_q[$];
    string phase = "init";

    // Reference model: lamp is lit or not, plus how many consecutive quiet edges it has seen.
    bit m_lit = 1'b0;
    int m_quiet = 0;

    lighting dut (
        .clk          (clk),
        .rst          (rst),
        .luminosity   (luminosity),
        .motionSensor (motionSensor),
        .light        (light)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: light=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic m, input int l);
        @(negedge clk);
        rst          = r;
        motionSensor = m;
        luminosity   = 3'(l);
        if (r) begin
            m_lit = 1'b0;
            m_quiet = 0;
        end else if (l >= OFF_T) begin
            m_lit = 1'b0;
            m_quiet = 0;
        end else if (!m_lit) begin
            m_lit = m && (l <= ON_T);
            m_quiet = 0;
        end else if (m) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            // Lit through HOLD quiet edges after the first quiet one, off on the next.
            if (m_quiet > HOLD) begin
                m_lit = 1'b0;
                m_quiet = 0;
            end
        end
        exp_q.push_back(m_lit);
        tag_q.push_back(phase);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                bit    e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, light, e);
            end
        end
    end

    initial begin : stimulus
        // Reset with motion in darkness, then the first free edge turns the lamp on.
        phase = "reset_hold";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0);
        phase = "reset_release";
        step(1'b0, 1'b1, 0);

        // Motion on, brightness rising then falling through the hysteresis band.
        phase = "lum_up";
        step(1'b1, 1'b0, 0);
        for (int l = 0; l <= 7; l++) step(1'b0, 1'b1, l);
        phase = "lum_down";
        for (int l = 7; l >= 0; l--) step(1'b0, 1'b1, l);

        // Full hold timeout at lum=2.
        phase = "hold_timeout";
        step(1'b0, 1'b1, 2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2);

        // Retrigger on the 4th quiet edge.
        phase = "hold_retrigger";
        step(1'b0, 1'b1, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4);

        // No motion: sweeping brightness never lights the lamp.
        phase = "no_motion_sweep";
        for (int l = 0; l <= 7; l++) step(1'b0, 1'b0, l);
        for (int l = 7; l >= 0; l--) step(1'b0, 1'b0, l);

        // Brightness ends HOLD early, at a few different timer values.
        phase = "hold_bright";
        for (int k = 1; k <= 6; k += 2) begin
            step(1'b0, 1'b1, 1);
            for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1);
            step(1'b0, 1'b0, 6);
        end

        // Reset while ON and while in HOLD.
        phase = "reset_mid";
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
